// File: rtl/DM.sv
// Shared Debug Module package: DMI request/response types, Gray-code
// helpers and the clear-handshake state encodings used by dmi_cdc_afifo.
package DM;

    // Widest pointer the Gray helpers handle; narrower pointers are
    // zero-extended in and truncated out, which leaves the result unchanged.
    localparam int unsigned GRAY_MAX_W = 16;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    // JTAG-side (initiator) clear handshake states.
    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_REQ,
        CLR_ACKD,
        CLR_WAIT
    } dmi_clr_src_e;

    // Core-side (responder) clear handshake states.
    typedef enum logic {
        CLR_D_IDLE,
        CLR_D_ACK
    } dmi_clr_dst_e;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/dmi_cdc_afifo_ch.sv
// One direction of the DMI crossing: asynchronous FIFO with Gray pointers
// and SYNC_STAGES-deep synchronisers. src_clear_i / dst_clear_i hold the
// respective side's pointers and synchronisers at zero.
// Optional source-side occupancy output under DMI_CDC_AFIFO_LEVEL_EN.
module dmi_cdc_afifo_ch
    import DM::*;
#(
    parameter type         T           = logic,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    src_clk_i,
    input  logic                    src_rst_ni,
    input  logic                    src_clear_i,
    input  T                        src_data_i,
    input  logic                    src_valid_i,
    output logic                    src_ready_o,
`ifdef DMI_CDC_AFIFO_LEVEL_EN
    output logic [$clog2(DEPTH):0]  src_level_o,
`endif
    input  logic                    dst_clk_i,
    input  logic                    dst_rst_ni,
    input  logic                    dst_clear_i,
    output T                        dst_data_o,
    output logic                    dst_valid_o,
    input  logic                    dst_ready_i
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    typedef logic [PW-1:0] ptr_t;
    // Full: write Gray equals read Gray with the two top bits inverted.
    localparam ptr_t FULL_MASK = ptr_t'(3) << (PW - 2);

    T     mem [DEPTH];
    ptr_t wbin_q, wgray_q, rbin_q, rgray_q;
    ptr_t rsync_q [SYNC_STAGES];
    ptr_t wsync_q [SYNC_STAGES];
    logic src_live_q;
    ptr_t wgray_now, rgray_now;
    logic full, empty, push, pop;

    assign wgray_now   = ptr_t'(bin2gray(GRAY_MAX_W'(wbin_q)));
    assign rgray_now   = ptr_t'(bin2gray(GRAY_MAX_W'(rbin_q)));
    // Full uses the live write pointer so the entry just pushed counts at once.
    assign full        = ((wgray_now ^ FULL_MASK) == rsync_q[SYNC_STAGES-1]);
    assign empty       = (rgray_now == wsync_q[SYNC_STAGES-1]);
    assign src_ready_o = src_live_q && !full && !src_clear_i;
    assign push        = src_valid_i && src_ready_o;
    assign dst_valid_o = !empty && !dst_clear_i;
    assign pop         = dst_valid_o && dst_ready_i;
    assign dst_data_o  = mem[rbin_q[AW-1:0]];

    // Source pointer; its Gray copy lags one cycle so a push coinciding
    // with the start of a clear never becomes visible to the destination.
    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            src_live_q <= 1'b0;
        end else begin
            src_live_q <= 1'b1;
            if (src_clear_i) begin
                wbin_q  <= '0;
                wgray_q <= '0;
            end else begin
                if (push) wbin_q <= wbin_q + ptr_t'(1);
                wgray_q <= wgray_now;
            end
        end
    end

    // Storage written in the source domain.
    always_ff @(posedge src_clk_i) begin
        if (push) mem[wbin_q[AW-1:0]] <= src_data_i;
    end

    // Read-pointer synchroniser into the source domain.
    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) rsync_q[i] <= '0;
        end else if (src_clear_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) rsync_q[i] <= '0;
        end else begin
            rsync_q[0] <= rgray_q;
            for (int i = 1; i < SYNC_STAGES; i++) rsync_q[i] <= rsync_q[i-1];
        end
    end

    // Destination pointer and its registered Gray copy.
    always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
        if (!dst_rst_ni) begin
            rbin_q  <= '0;
            rgray_q <= '0;
        end else if (dst_clear_i) begin
            rbin_q  <= '0;
            rgray_q <= '0;
        end else begin
            if (pop) rbin_q <= rbin_q + ptr_t'(1);
            rgray_q <= rgray_now;
        end
    end

    // Write-pointer synchroniser into the destination domain.
    always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
        if (!dst_rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) wsync_q[i] <= '0;
        end else if (dst_clear_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) wsync_q[i] <= '0;
        end else begin
            wsync_q[0] <= wgray_q;
            for (int i = 1; i < SYNC_STAGES; i++) wsync_q[i] <= wsync_q[i-1];
        end
    end

`ifdef DMI_CDC_AFIFO_LEVEL_EN
    ptr_t rbin_synced;
    assign rbin_synced = ptr_t'(gray2bin(GRAY_MAX_W'(rsync_q[SYNC_STAGES-1])));
    assign src_level_o = src_clear_i ? '0 : (wbin_q - rbin_synced);
`endif

endmodule

// File: rtl/dmi_cdc_afifo.sv
// Multi-entry DMI clock-domain crossing between the DTM (tck_i) and the
// DM (clk_i). Two async FIFOs plus a four-phase clear handshake that
// flushes both and emits an active-low pulse on core_dmi_rst_no.
// Optional occupancy outputs: define DMI_CDC_AFIFO_LEVEL_EN.
module dmi_cdc_afifo
    import DM::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned CLR_PULSE_LEN = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   tck_i,
    input  logic                   trst_ni,
    input  dmi_req_t               jtag_dmi_req_i,
    input  logic                   jtag_dmi_valid_i,
    output logic                   jtag_dmi_ready_o,
    output dmi_resp_t              jtag_dmi_resp_o,
    output logic                   jtag_dmi_valid_o,
    input  logic                   jtag_dmi_ready_i,
    input  logic                   jtag_dmi_clear_i,
    output logic                   jtag_clear_busy_o,
    output logic                   core_dmi_rst_no,
    output dmi_req_t               core_dmi_req_o,
    output logic                   core_dmi_valid_o,
    input  logic                   core_dmi_ready_i,
    input  dmi_resp_t              core_dmi_resp_i,
    input  logic                   core_dmi_valid_i,
`ifdef DMI_CDC_AFIFO_LEVEL_EN
    output logic [$clog2(DEPTH):0] jtag_req_level_o,
    output logic [$clog2(DEPTH):0] core_resp_level_o,
`endif
    output logic                   core_dmi_ready_o
);

    localparam logic [3:0] PULSE_LAST = 4'(CLR_PULSE_LEN - 1);

    dmi_clr_src_e           jtag_state_q;
    logic                   jtag_busy_q, jtag_clr_req_q;
    logic [SYNC_STAGES-1:0] jtag_ack_sync_q;
    logic                   jtag_ack_synced;

    dmi_clr_dst_e           core_state_q;
    logic                   core_ack_q, core_rst_n_q;
    logic [3:0]             core_pulse_cnt_q;
    logic [SYNC_STAGES-1:0] core_req_sync_q;
    logic                   core_req_synced;
    logic                   core_clearing;

    assign jtag_ack_synced   = jtag_ack_sync_q[SYNC_STAGES-1];
    assign core_req_synced   = core_req_sync_q[SYNC_STAGES-1];
    assign jtag_clear_busy_o = jtag_busy_q;
    assign core_dmi_rst_no   = core_rst_n_q;
    // The synced request already blocks the core side one cycle before ACK,
    // so the zeroed JTAG pointers can never look like stale entries here.
    assign core_clearing     = core_ack_q || core_req_synced;

    // Ack synchroniser into the TCK domain.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) jtag_ack_sync_q <= '0;
        else          jtag_ack_sync_q <= {jtag_ack_sync_q[SYNC_STAGES-2:0], core_ack_q};
    end

    // JTAG clear initiator; clear pulses outside IDLE are ignored.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            jtag_state_q   <= CLR_IDLE;
            jtag_busy_q    <= 1'b0;
            jtag_clr_req_q <= 1'b0;
        end else begin
            case (jtag_state_q)
                CLR_IDLE: if (jtag_dmi_clear_i) begin
                    jtag_state_q   <= CLR_REQ;
                    jtag_busy_q    <= 1'b1;
                    jtag_clr_req_q <= 1'b1;
                end
                CLR_REQ:  if (jtag_ack_synced) jtag_state_q <= CLR_ACKD;
                CLR_ACKD: begin
                    jtag_state_q   <= CLR_WAIT;
                    jtag_clr_req_q <= 1'b0;
                end
                CLR_WAIT: if (!jtag_ack_synced) begin
                    jtag_state_q <= CLR_IDLE;
                    jtag_busy_q  <= 1'b0;
                end
                default:  jtag_state_q <= CLR_IDLE;
            endcase
        end
    end

    // Request synchroniser into the core domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) core_req_sync_q <= '0;
        else         core_req_sync_q <= {core_req_sync_q[SYNC_STAGES-2:0], jtag_clr_req_q};
    end

    // Core clear responder with the reset-pulse counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            core_state_q     <= CLR_D_IDLE;
            core_ack_q       <= 1'b0;
            core_rst_n_q     <= 1'b1;
            core_pulse_cnt_q <= '0;
        end else begin
            case (core_state_q)
                CLR_D_IDLE: if (core_req_synced) begin
                    core_state_q     <= CLR_D_ACK;
                    core_ack_q       <= 1'b1;
                    core_rst_n_q     <= 1'b0;
                    core_pulse_cnt_q <= PULSE_LAST;
                end
                CLR_D_ACK: begin
                    if (core_pulse_cnt_q != '0) core_pulse_cnt_q <= core_pulse_cnt_q - 4'd1;
                    else                        core_rst_n_q     <= 1'b1;
                    if (!core_req_synced && core_rst_n_q && core_pulse_cnt_q == '0) begin
                        core_state_q <= CLR_D_IDLE;
                        core_ack_q   <= 1'b0;
                    end
                end
                default: core_state_q <= CLR_D_IDLE;
            endcase
        end
    end

    dmi_cdc_afifo_ch #(
        .T(dmi_req_t), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)
    ) i_req_ch (
        .src_clk_i   (tck_i),
        .src_rst_ni  (trst_ni),
        .src_clear_i (jtag_busy_q),
        .src_data_i  (jtag_dmi_req_i),
        .src_valid_i (jtag_dmi_valid_i),
        .src_ready_o (jtag_dmi_ready_o),
`ifdef DMI_CDC_AFIFO_LEVEL_EN
        .src_level_o (jtag_req_level_o),
`endif
        .dst_clk_i   (clk_i),
        .dst_rst_ni  (rst_ni),
        .dst_clear_i (core_clearing),
        .dst_data_o  (core_dmi_req_o),
        .dst_valid_o (core_dmi_valid_o),
        .dst_ready_i (core_dmi_ready_i)
    );

    dmi_cdc_afifo_ch #(
        .T(dmi_resp_t), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)
    ) i_resp_ch (
        .src_clk_i   (clk_i),
        .src_rst_ni  (rst_ni),
        .src_clear_i (core_clearing),
        .src_data_i  (core_dmi_resp_i),
        .src_valid_i (core_dmi_valid_i),
        .src_ready_o (core_dmi_ready_o),
`ifdef DMI_CDC_AFIFO_LEVEL_EN
        .src_level_o (core_resp_level_o),
`endif
        .dst_clk_i   (tck_i),
        .dst_rst_ni  (trst_ni),
        .dst_clear_i (jtag_busy_q),
        .dst_data_o  (jtag_dmi_resp_o),
        .dst_valid_o (jtag_dmi_valid_o),
        .dst_ready_i (jtag_dmi_ready_i)
    );

endmodule

// File: tb/tb_dmi_cdc_afifo.sv
// Directed bench for dmi_cdc_afifo (DEPTH=4, SYNC_STAGES=2, CLR_PULSE_LEN=3).
module tb_dmi_cdc_afifo;
    import DM::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned PLEN  = 3;

    logic      clk_i = 1'b0, tck_i = 1'b0, rst_ni, trst_ni;
    int        tck_half = 5;
    dmi_req_t  jtag_dmi_req_i, core_dmi_req_o;
    dmi_resp_t jtag_dmi_resp_o, core_dmi_resp_i;
    logic      jtag_dmi_valid_i, jtag_dmi_ready_o, jtag_dmi_valid_o, jtag_dmi_ready_i;
    logic      jtag_dmi_clear_i, jtag_clear_busy_o, core_dmi_rst_no;
    logic      core_dmi_valid_o, core_dmi_ready_i, core_dmi_valid_i, core_dmi_ready_o;
`ifdef DMI_CDC_AFIFO_LEVEL_EN
    logic [$clog2(DEPTH):0] jtag_req_level_o, core_resp_level_o;
`endif

    dmi_cdc_afifo #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .CLR_PULSE_LEN(PLEN)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .tck_i             (tck_i),
        .trst_ni           (trst_ni),
        .jtag_dmi_req_i    (jtag_dmi_req_i),
        .jtag_dmi_valid_i  (jtag_dmi_valid_i),
        .jtag_dmi_ready_o  (jtag_dmi_ready_o),
        .jtag_dmi_resp_o   (jtag_dmi_resp_o),
        .jtag_dmi_valid_o  (jtag_dmi_valid_o),
        .jtag_dmi_ready_i  (jtag_dmi_ready_i),
        .jtag_dmi_clear_i  (jtag_dmi_clear_i),
        .jtag_clear_busy_o (jtag_clear_busy_o),
        .core_dmi_rst_no   (core_dmi_rst_no),
        .core_dmi_req_o    (core_dmi_req_o),
        .core_dmi_valid_o  (core_dmi_valid_o),
        .core_dmi_ready_i  (core_dmi_ready_i),
        .core_dmi_resp_i   (core_dmi_resp_i),
        .core_dmi_valid_i  (core_dmi_valid_i),
`ifdef DMI_CDC_AFIFO_LEVEL_EN
        .jtag_req_level_o  (jtag_req_level_o),
        .core_resp_level_o (core_resp_level_o),
`endif
        .core_dmi_ready_o  (core_dmi_ready_o)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk_i = ~clk_i;
    initial begin
        #2;
        forever #tck_half tck_i = ~tck_i;
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    // ---------------- checking ----------------
    int total = 0, bad = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboards / monitors ----------------
    logic [40:0] req_exp_q[$];
    logic [33:0] rsp_exp_q[$];
    int req_seen = 0, rsp_seen = 0;
    int busy_rises = 0, rst_pulses = 0, rst_low_cycles = 0;
    logic busy_prev = 1'b0, rst_prev = 1'b1;
    logic rand_rdy_en = 1'b0;

    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && core_dmi_valid_o && core_dmi_ready_i) begin
            req_seen++;
            if (req_exp_q.size() == 0) check("req_extra", 64'(req_exp_q.size()), 64'd1);
            else                       check("req_data", 64'(core_dmi_req_o), 64'(req_exp_q.pop_front()));
        end
        if (!core_dmi_rst_no) rst_low_cycles++;
        if (!core_dmi_rst_no && rst_prev) rst_pulses++;
        rst_prev = core_dmi_rst_no;
    end

    always @(negedge tck_i) begin
        if (trst_ni === 1'b1 && jtag_dmi_valid_o && jtag_dmi_ready_i) begin
            rsp_seen++;
            if (rsp_exp_q.size() == 0) check("rsp_extra", 64'(rsp_exp_q.size()), 64'd1);
            else                       check("rsp_data", 64'(jtag_dmi_resp_o), 64'(rsp_exp_q.pop_front()));
        end
        if (jtag_clear_busy_o && !busy_prev) busy_rises++;
        busy_prev = jtag_clear_busy_o;
    end

    always @(posedge tck_i) begin
        if (rand_rdy_en) begin
            #1;
            jtag_dmi_ready_i = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- drivers ----------------
    function automatic dmi_req_t mk_req(input logic [6:0] a, input logic [31:0] d);
        dmi_req_t r;
        r.addr = a;
        r.op   = DTM_WRITE;
        r.data = d;
        return r;
    endfunction

    task automatic jtag_push(input dmi_req_t r, output bit ok);
        int n = 0;
        @(negedge tck_i);
        jtag_dmi_req_i   = r;
        jtag_dmi_valid_i = 1'b1;
        while (!jtag_dmi_ready_o && n < 200) begin
            @(negedge tck_i);
            n++;
        end
        ok = jtag_dmi_ready_o;
        if (ok) req_exp_q.push_back(r);
        @(posedge tck_i);
        #1;
        jtag_dmi_valid_i = 1'b0;
    endtask

    task automatic core_push(input dmi_resp_t r, output bit ok);
        int n = 0;
        @(negedge clk_i);
        core_dmi_resp_i  = r;
        core_dmi_valid_i = 1'b1;
        while (!core_dmi_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        ok = core_dmi_ready_o;
        if (ok) rsp_exp_q.push_back(r);
        @(posedge clk_i);
        #1;
        core_dmi_valid_i = 1'b0;
    endtask

    task automatic set_core_ready(input logic v);
        @(posedge clk_i);
        #1;
        core_dmi_ready_i = v;
    endtask

    task automatic pulse_clear();
        @(negedge tck_i);
        jtag_dmi_clear_i = 1'b1;
        @(posedge tck_i);
        #1;
        jtag_dmi_clear_i = 1'b0;
    endtask

    task automatic wait_req_drain(input string tag);
        int n = 0;
        while (req_exp_q.size() != 0 && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        check(tag, 64'(req_exp_q.size()), 64'd0);
    endtask

    task automatic wait_busy_low(input string tag);
        int n = 0;
        while (jtag_clear_busy_o && n < 500) begin
            @(negedge tck_i);
            n++;
        end
        check(tag, 64'(jtag_clear_busy_o), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] burst_data [6] = '{32'h11111111, 32'h22222222, 32'h33333333,
                                    32'h44444444, 32'h55555555, 32'h66666666};
    logic [31:0] rsp_data [5]   = '{32'hA0A0A0A0, 32'h0BADF00D, 32'hCAFEBABE,
                                    32'h12345678, 32'hFFFF0000};

    initial begin
        bit ok;
        int n, base_seen, base_rises, base_pulses, base_low;
        dmi_req_t r;
        dmi_resp_t rs;

        jtag_dmi_req_i   = '0;
        jtag_dmi_valid_i = 1'b0;
        jtag_dmi_ready_i = 1'b0;
        jtag_dmi_clear_i = 1'b0;
        core_dmi_ready_i = 1'b0;
        core_dmi_resp_i  = '0;
        core_dmi_valid_i = 1'b0;
        rst_ni  = 1'b0;
        trst_ni = 1'b0;

        // Reset values while both resets are asserted.
        #33;
        check("rst_jtag_ready", 64'(jtag_dmi_ready_o), 64'd0);
        check("rst_jtag_valid", 64'(jtag_dmi_valid_o), 64'd0);
        check("rst_busy", 64'(jtag_clear_busy_o), 64'd0);
        check("rst_core_valid", 64'(core_dmi_valid_o), 64'd0);
        check("rst_core_ready", 64'(core_dmi_ready_o), 64'd0);
        check("rst_core_rst_no", 64'(core_dmi_rst_no), 64'd1);
        #7;
        rst_ni  = 1'b1;
        trst_ni = 1'b1;
        repeat (4) @(negedge tck_i);
        check("rel_jtag_ready", 64'(jtag_dmi_ready_o), 64'd1);
        check("rel_core_valid", 64'(core_dmi_valid_o), 64'd0);
        check("rel_core_ready", 64'(core_dmi_ready_o), 64'd1);
        check("rel_core_rst_no", 64'(core_dmi_rst_no), 64'd1);

        // Single request: valid appears on the third clk_i edge after the push.
        r = mk_req(7'h10, 32'hDEADBEEF);
        jtag_push(r, ok);
        check("single_push_ok", 64'(ok), 64'd1);
        n = 0;
        while (!core_dmi_valid_o && n < 20) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("single_latency", 64'(n), 64'd3);
        check("single_data", 64'(core_dmi_req_o), {23'd0, 7'h10, 2'h2, 32'hDEADBEEF});
        set_core_ready(1'b1);
        wait_req_drain("single_drain");
        set_core_ready(1'b0);
        repeat (10) @(negedge tck_i);

        // Burst of 6 against a stalled core: only DEPTH entries fit.
        base_seen = req_seen;
        for (int i = 0; i < 4; i++) begin
            jtag_push(mk_req(7'(8'h20 + i), burst_data[i]), ok);
            check("burst_push_ok", 64'(ok), 64'd1);
        end
        @(negedge tck_i);
        check("burst_full_ready", 64'(jtag_dmi_ready_o), 64'd0);
        set_core_ready(1'b1);
        for (int i = 4; i < 6; i++) begin
            jtag_push(mk_req(7'(8'h20 + i), burst_data[i]), ok);
            check("burst_push_late_ok", 64'(ok), 64'd1);
        end
        wait_req_drain("burst_drain");
        check("burst_count", 64'(req_seen - base_seen), 64'd6);

        // Response stream with slow TCK and random DTM ready.
        tck_half = 15;
        repeat (2) @(negedge tck_i);
        rand_rdy_en = 1'b1;
        base_seen = rsp_seen;
        for (int i = 0; i < 5; i++) begin
            rs.data = rsp_data[i];
            rs.resp = 2'(i);
            core_push(rs, ok);
            check("rsp_push_ok", 64'(ok), 64'd1);
        end
        n = 0;
        while (rsp_exp_q.size() != 0 && n < 1000) begin
            @(negedge tck_i);
            n++;
        end
        check("rsp_drain", 64'(rsp_exp_q.size()), 64'd0);
        check("rsp_count", 64'(rsp_seen - base_seen), 64'd5);
        rand_rdy_en = 1'b0;
        tck_half = 5;
        repeat (3) @(negedge tck_i);
        jtag_dmi_ready_i = 1'b0;

        // Clear with 3 queued requests and one queued response.
        set_core_ready(1'b0);
        for (int i = 0; i < 3; i++) begin
            jtag_push(mk_req(7'(8'h30 + i), 32'hC0DE0000 + i), ok);
            check("clr_push_ok", 64'(ok), 64'd1);
        end
        rs.data = 32'h5A5A5A5A;
        rs.resp = 2'h0;
        core_push(rs, ok);
        repeat (10) @(negedge tck_i);
        check("clr_pre_core_valid", 64'(core_dmi_valid_o), 64'd1);
        check("clr_pre_jtag_valid", 64'(jtag_dmi_valid_o), 64'd1);
        base_rises  = busy_rises;
        base_pulses = rst_pulses;
        base_low    = rst_low_cycles;
        pulse_clear();
        req_exp_q.delete();
        rsp_exp_q.delete();
        @(negedge tck_i);
        check("clr_busy_high", 64'(jtag_clear_busy_o), 64'd1);
        wait_busy_low("clr_busy_low");
        repeat (6) @(negedge tck_i);
        check("clr_core_valid", 64'(core_dmi_valid_o), 64'd0);
        check("clr_jtag_valid", 64'(jtag_dmi_valid_o), 64'd0);
        check("clr_jtag_ready", 64'(jtag_dmi_ready_o), 64'd1);
        check("clr_core_ready", 64'(core_dmi_ready_o), 64'd1);
        check("clr_rst_low_len", 64'(rst_low_cycles - base_low), 64'(PLEN));
        check("clr_rst_pulses", 64'(rst_pulses - base_pulses), 64'd1);
        check("clr_handshakes", 64'(busy_rises - base_rises), 64'd1);
        jtag_dmi_ready_i = 1'b1;
        set_core_ready(1'b1);
        base_seen = req_seen;
        jtag_push(mk_req(7'h11, 32'h600DF00D), ok);
        check("post_clr_push_ok", 64'(ok), 64'd1);
        wait_req_drain("post_clr_drain");
        check("post_clr_count", 64'(req_seen - base_seen), 64'd1);

        // Push together with clear, then a second clear while busy.
        repeat (10) @(negedge tck_i);
        base_seen   = req_seen;
        base_rises  = busy_rises;
        base_pulses = rst_pulses;
        @(negedge tck_i);
        jtag_dmi_req_i   = mk_req(7'h7F, 32'hBAD0BAD0);
        jtag_dmi_valid_i = 1'b1;
        jtag_dmi_clear_i = 1'b1;
        @(posedge tck_i);
        #1;
        jtag_dmi_valid_i = 1'b0;
        jtag_dmi_clear_i = 1'b0;
        repeat (3) @(negedge tck_i);
        check("dbl_busy_high", 64'(jtag_clear_busy_o), 64'd1);
        pulse_clear();
        wait_busy_low("dbl_busy_low");
        repeat (30) @(negedge tck_i);
        check("dbl_busy_idle", 64'(jtag_clear_busy_o), 64'd0);
        check("dbl_handshakes", 64'(busy_rises - base_rises), 64'd1);
        check("dbl_rst_pulses", 64'(rst_pulses - base_pulses), 64'd1);
        check("dbl_no_req", 64'(req_seen - base_seen), 64'd0);
        check("dbl_core_valid", 64'(core_dmi_valid_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmi_cdc_afifo.md
# dmi_cdc_afifo

Parametrised clock-domain crossing for the Debug Module Interface (DMI). Request and response each cross between the JTAG TCK domain and the core clock domain through an asynchronous FIFO of configurable depth, so multiple DMI transactions can be in flight. A four-phase clear handshake flushes both FIFOs together and produces a configurable-length active-low reset pulse toward the DM CSR logic. The block sits between the DTM and the DM, and is the multi-entry successor of the single-entry two-phase DMI crossing.

## Interface
- DEPTH, 4: entries per FIFO; power of two, ≥2.
- SYNC_STAGES, 2: flip-flops per synchroniser chain; ≥2.
- CLR_PULSE_LEN, 1: core-domain length of `core_dmi_rst_no` low pulse, in cycles; 1..15.
- clk_i  in  1  core clock.
- rst_ni  in  1  core reset, asynchronous, active-low.
- tck_i  in  1  JTAG clock.
- trst_ni  in  1  JTAG reset, asynchronous, active-low.
- jtag_dmi_req_i  in  DM::dmi_req_t  request from DTM.
- jtag_dmi_valid_i / jtag_dmi_ready_o  in/out  1  request handshake (TCK).
- jtag_dmi_resp_o  out  DM::dmi_resp_t  response to DTM.
- jtag_dmi_valid_o / jtag_dmi_ready_i  out/in  1  response handshake (TCK).
- jtag_dmi_clear_i  in  1  one-cycle clear request (TCK).
- jtag_clear_busy_o  out  1  clear handshake in progress (TCK).
- core_dmi_rst_no  out  1  active-low clear pulse (clk_i).
- core_dmi_req_o, core_dmi_valid_o / core_dmi_ready_i  out/out/in  request to DM.
- core_dmi_resp_i, core_dmi_valid_i / core_dmi_ready_o  in/in/out  response from DM.

## Operation
- Each FIFO: binary write and read pointers of $clog2(DEPTH)+1 bits, with Gray-coded copies registered before SYNC_STAGES-deep synchronisers. Full when the Gray write pointer equals the synced read pointer with the top two bits inverted. Empty when the pointers are equal. Storage is a flop array written in the source domain and read combinationally in the destination domain.
- Source side: `ready` = !full && !clearing. A push occurs on valid && ready.
- Destination side: `valid` = !empty && !clearing. A pop occurs on valid && ready.
- Data is held stable while valid && !ready.
- JTAG clear FSM states: IDLE → REQ on `jtag_dmi_clear_i`. REQ → ACKD when the synced ack = 1. ACKD → WAIT in the next cycle, which drops the request. WAIT → IDLE when the synced ack = 0.
- In every state except IDLE, the JTAG-side pointers are held at 0 and `jtag_clear_busy_o` = 1.
- A clear pulse received while not in IDLE is ignored.
- Core clear FSM states: IDLE → ACK when the synced request = 1. In ACK, the core-side pointers are held at 0, ack = 1, and a pulse counter drives `core_dmi_rst_no` low for CLR_PULSE_LEN cycles, starting in the first ACK cycle. ACK → IDLE when the synced request = 0 and the pulse is done.
- Synced pointer registers in both domains reset to 0 while their side is clearing.
- Simultaneous push and clear on the same TCK edge: the clear wins and the push is discarded. In-flight responses are discarded.
- Reset: each domain's reset clears only that domain's pointers, synchronisers and FSM. Asserting one domain's reset alone is not supported without a subsequent clear.

## Timing
- Reset values: `jtag_dmi_ready_o` = 0 while `trst_ni` is low, then 1 (the FIFO is empty). `jtag_dmi_valid_o` = 0. `jtag_clear_busy_o` = 0. `core_dmi_valid_o` = 0. `core_dmi_ready_o` = 0 while `rst_ni` is low, then 1. `core_dmi_rst_no` = 1.
- Push to destination valid: 1 source cycle plus SYNC_STAGES+1 destination cycles.
- Pop to `ready` reasserting after full: 1 destination cycle plus SYNC_STAGES+1 source cycles.
- Full-throughput streaming is sustained when DEPTH ≥ 2·(SYNC_STAGES+2) for equal clocks.
- Clear: `jtag_clear_busy_o` rises in the cycle after `jtag_dmi_clear_i`. The total handshake takes about 2·(SYNC_STAGES+1) cycles of each clock.

## Configuration
- `DMI_CDC_AFIFO_LEVEL_EN`: when defined, adds outputs `jtag_req_level_o` and `core_resp_level_o`, each $clog2(DEPTH)+1 bits. Each is the source-side occupancy of its FIFO: write pointer minus synced read pointer, converted from Gray to binary, modulo 2^(width). Each is 0 during reset and clear.
- When not defined, these ports and their Gray-to-binary logic do not exist.

## Structure
- `DM::dmi_req_t` and `DM::dmi_resp_t` stay in the shared `DM` package.
- Add to package `DM`:
  - `function bin2gray`
  - `function gray2bin` (parametrised width via a let/loop)
  - `typedef enum {CLR_IDLE, CLR_REQ, CLR_ACKD, CLR_WAIT}` as `dmi_clr_src_e`
- One sub-module is instantiated twice: `dmi_cdc_afifo_ch #(T, DEPTH, SYNC_STAGES)`. It provides one direction, with `src_clear_i`/`dst_clear_i` pointer-hold inputs.
- The clear FSMs and pulse counter live in the top level.

## Test plan
- Reset release, DEPTH=4, SYNC_STAGES=2: JTAG ready = 1, core valid = 0, `core_dmi_rst_no` = 1.
- Single request (addr 0x10, data 0xDEADBEEF, op write): `core_dmi_valid_o` rises 3 clk_i cycles after the push. The data matches.
- Burst of 6 with core_ready = 0: 4 are accepted. `jtag_dmi_ready_o` = 0 after the 4th. Releasing core_ready delivers all 6 in order with no loss.
- Response stream of 5 with tck at 1/3 of the clk_i rate and random jtag_ready: all 5 arrive in order, data unchanged.
- Clear with 3 requests queued and CLR_PULSE_LEN=3:
  - `core_dmi_valid_o` drops.
  - `core_dmi_rst_no` is low for exactly 3 cycles.
  - busy returns to 0.
  - Both FIFOs are empty. The next request passes normally.
- A clear pulse during busy, and a push in the same cycle as the clear: both are ignored. Exactly one handshake completes, and no request reaches the core.
